// File: rtl/alu_ctrl_multiciclo.sv
// ALU control decoder with a multi-cycle signed mul/div sequencer.
// Results are written to HI/LO; busy/done give a start handshake.
module alu_ctrl_multiciclo #(
  parameter int         WIDTH      = 32,
  parameter logic [2:0] DEFAULT_OP = 3'b010
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [1:0]       opALU,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       sinalOperacao,
  output logic             ilegal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic               r_sa;
  logic               r_sb;
  logic               r_isdiv;
  logic               r_dz;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_divzero;

  logic [2:0]         w_op;
  logic               w_ilegal;
  logic               w_go;
  logic               w_ismul;
  logic               w_bzero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rsh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rdiff;
  logic [WIDTH-1:0]   w_rnew;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_qs;
  logic [WIDTH-1:0]   w_rs;

  // ALU control decode; first match wins, everything else is illegal
  always_comb begin
    w_op     = DEFAULT_OP;
    w_ilegal = 1'b1;
    case (opALU)
      2'b00: begin
        w_op     = 3'b010;
        w_ilegal = 1'b0;
      end
      2'b01: begin
        w_op     = 3'b110;
        w_ilegal = 1'b0;
      end
      2'b10: begin
        w_ilegal = 1'b0;
        case (funct)
          6'b100100: w_op = 3'b000;
          6'b100101: w_op = 3'b001;
          6'b100000: w_op = 3'b010;
          6'b000010: w_op = 3'b011;
          6'b011010: w_op = 3'b100;
          6'b100010: w_op = 3'b110;
          6'b101010: w_op = 3'b111;
          default:   w_ilegal = 1'b1;
        endcase
      end
      default: w_ilegal = 1'b1;
    endcase
  end

  assign sinalOperacao = w_op;
  assign ilegal        = w_ilegal;

  assign w_ismul = (w_op == 3'b011);
  assign w_go    = (r_state == S_IDLE) && start && !w_ilegal
                   && (w_ismul || (w_op == 3'b100));
  assign w_bzero = (b == '0);
  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;

  // One shift-add step: add multiplicand when LSB set, then shift right
  assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                     + (r_p[0] ? {1'b0, r_m} : '0);

  // One restoring-division step on {remainder, dividend}
  assign w_rsh   = r_p[2*WIDTH-1:WIDTH-1];
  assign w_ge    = (w_rsh >= {1'b0, r_m});
  assign w_rdiff = w_rsh[WIDTH-1:0] - r_m;
  assign w_rnew  = w_ge ? w_rdiff : w_rsh[WIDTH-1:0];

  // Sign correction applied in FIX
  assign w_prod = (r_sa ^ r_sb) ? -r_p : r_p;
  assign w_q    = r_p[WIDTH-1:0];
  assign w_r    = r_p[2*WIDTH-1:WIDTH];
  assign w_qs   = (r_sa ^ r_sb) ? -w_q : w_q;
  assign w_rs   = r_sa ? -w_r : w_r;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (w_ismul)      w_next = S_MUL;
          else if (w_bzero) w_next = S_FIX;
          else              w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == CW'(1)) w_next = S_FIX;
      end
      S_FIX: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_p       <= '0;
      r_m       <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_isdiv   <= 1'b0;
      r_dz      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_busy    <= 1'b1;
            r_divzero <= 1'b0;
            r_cnt     <= CW'(WIDTH);
            r_sa      <= a[WIDTH-1];
            r_sb      <= b[WIDTH-1];
            r_isdiv   <= !w_ismul;
            r_dz      <= !w_ismul && w_bzero;
            r_m       <= w_ismul ? w_abs_a : w_abs_b;
            r_p       <= {{WIDTH{1'b0}},
                          (w_ismul ? w_abs_b : w_abs_a)};
          end
        end
        S_MUL: begin
          r_p   <= {w_mul_sum, r_p[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_p   <= {w_rnew, r_p[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
          if (r_dz) begin
            // r_p low half still holds |a|; rebuild a
            r_hi      <= r_sa ? -w_q : w_q;
            r_lo      <= '1;
            r_divzero <= 1'b1;
          end else if (r_isdiv) begin
            r_hi <= w_rs;
            r_lo <= w_qs;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign divZero = r_divzero;

endmodule

// File: doc/alu_ctrl_multiciclo.md
# alu_ctrl_multiciclo

Parametrised successor of the processor's ALU control decoder. It keeps the single-cycle funct/opALU → sinalOperacao decode for the datapath ALU. It adds a sequencer that runs the multi-cycle signed multiply and divide internally with a start/busy/done handshake, so the control unit can stall on busy. Results land in HI/LO registers for the mfhi/mflo path.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; legal range is 4 or more.
- DEFAULT_OP, 3'b010, sinalOperacao value driven for an illegal or undefined decode.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  opcode and operands are valid this cycle.
- funct  in  6  instruction funct field.
- opALU  in  2  ALU op class from the main control.
- a  in  WIDTH  rs operand, two's complement.
- b  in  WIDTH  rt operand, two's complement.
- sinalOperacao  out  3  combinational ALU control code.
- ilegal  out  1  combinational; the current opALU/funct has no defined operation.
- busy  out  1  registered; a multiply or divide is in flight.
- done  out  1  registered; one-cycle pulse, HI/LO just updated.
- hi  out  WIDTH  registered; multiply upper half, or divide remainder.
- lo  out  WIDTH  registered; multiply lower half, or divide quotient.
- divZero  out  1  registered; the last divide had b == 0. Held until the next accepted start.

## Operation
- Decode is purely combinational. Priority is as listed below; the first match wins.
  - opALU=00 → 010 (add, lw/sw).
  - opALU=01 → 110 (sub, beq).
  - opALU=10, funct 100100 → 000 (and); 100101 → 001 (or); 100000 → 010 (add); 000010 → 011 (mul); 011010 → 100 (div); 100010 → 110 (sub); 101010 → 111 (slt).
  - Any other combination, including opALU=11 → DEFAULT_OP with ilegal=1. The block must not infer a latch; code 101 is never produced.
- Sequencer states: IDLE, MUL, DIV, FIX.
- IDLE: on start=1, with decode 011 or 100 and ilegal=0, the block does the following.
  - It latches the magnitudes |a| and |b| plus both sign bits.
  - It clears divZero, loads the iteration counter with WIDTH, and moves to MUL or DIV.
  - A start carrying any other decode is ignored by the sequencer.
- MUL: shift-add over the unsigned magnitudes, one bit per cycle for WIDTH cycles. After the last iteration the state goes to FIX.
- DIV: restoring division over the magnitudes, one quotient bit per cycle for WIDTH cycles, then FIX.
- DIV with b == 0 skips the iterations and goes straight to FIX with hi=a, lo=all ones and divZero=1. No sign fix is applied in this case.
- FIX: applies the sign correction, writes hi/lo, pulses done and returns to IDLE.
  - Multiply: the 2·WIDTH product is negated when the sign bits differ.
  - Divide: the quotient is negated when the sign bits differ; the remainder takes the sign of a.
- Width rules: magnitudes are WIDTH bits unsigned, so |−2^(WIDTH−1)| fits. The product is 2·WIDTH bits. Division of the most-negative value by −1 yields lo = most-negative and hi = 0, with no flag.
- start while busy=1 is ignored. Inputs a, b and funct may change freely during an operation.
- hi/lo hold their value between operations.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, divZero=0, state=IDLE, counter=0. The combinational outputs follow their inputs during reset.
- Accepted start at edge k: busy=1 after edge k.
- Normal operation, with done at edge k+WIDTH+1:
  - hi/lo update and done=1 after edge k+WIDTH+1, and busy=0 after that same edge.
  - Total latency is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- Divide by zero: done, hi/lo and divZero update after edge k+1; busy is high for one cycle only.
- done is high for exactly one cycle. A start sampled while done=1 is accepted, because the state is IDLE, so back-to-back operations lose no cycle.
- An asynchronous reset mid-operation aborts it: all registers return to their reset values at once, and no done pulse is emitted.

## Test plan
- Decode sweep:
  - opALU=00 → 010.
  - opALU=01 → 110.
  - opALU=10 with funct 100100 → 000, 101010 → 111, 000010 → 011.
  - opALU=10 with funct 000000 → 010 and ilegal=1.
  - opALU=11 → 010 and ilegal=1.
- mul, WIDTH=32, a=7, b=−3: busy is high for 33 cycles, then done pulses once with hi=FFFFFFFF and lo=FFFFFFEB. The same run with a=−2^31, b=−2^31 gives hi=40000000 and lo=00000000.
- div, a=−7, b=2: lo=FFFFFFFD and hi=FFFFFFFF after 33 cycles. a=−2^31, b=−1 gives lo=80000000 and hi=0.
- div, a=5, b=0: done after 1 cycle with hi=5, lo=FFFFFFFF and divZero=1. A following mul start clears divZero.
- Handshake:
  - A start during busy with different operands is ignored, and the result matches the first operands.
  - A start in the done cycle is accepted, and the second result arrives exactly 33 cycles later.
  - A start with an add decode leaves busy=0.
- Reset asserted asynchronously at cycle 10 of a mul: all outputs return to 0 with no done pulse. A new div started after release returns the correct result.
